// File: rtl/tp84_snd_pkg.sv
// Shared constants, lookup tables and FSM encoding for the TP84 volume/LPF output stage.
// The alpha table exists only when TP84_VOLUME_LPF_EN is defined.
package tp84_snd_pkg;

  localparam int SAMPLE_W = 16;

  // Q1.8 gain per dial position
  localparam logic [8:0] GAIN_TAB [0:7] = '{
    9'd0, 9'd37, 9'd73, 9'd110, 9'd146, 9'd183, 9'd219, 9'd256
  };

`ifdef TP84_VOLUME_LPF_EN
  // Q0.15 smoothing factor; louder dial settings give a darker amplifier response
  localparam logic [15:0] ALPHA_TAB [0:7] = '{
    16'd16384, 16'd14336, 16'd12288, 16'd10240,
    16'd8192,  16'd6144,  16'd4096,  16'd2048
  };
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAIN,
    ST_DIFF,
    ST_MAC,
    ST_OUT
  } state_t;

endpackage

// File: rtl/tp84_sat16.sv
// Saturating narrower from an IN_W-bit signed value to a SAMPLE_W-bit signed sample.
module tp84_sat16
  import tp84_snd_pkg::*;
#(
  parameter int IN_W = 34
) (
  input  logic signed [IN_W-1:0]     din,
  output logic signed [SAMPLE_W-1:0] dout
);

  // The value fits when every bit above the result's sign bit matches it.
  logic [IN_W-SAMPLE_W:0] top;
  assign top = din[IN_W-1:SAMPLE_W-1];

  always_comb begin
    if ((&top) || !(|top))
      dout = din[SAMPLE_W-1:0];
    else if (din[IN_W-1])
      dout = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      dout = {1'b0, {(SAMPLE_W-1){1'b1}}};
  end

endmodule

// File: rtl/tp84_volume_stage.sv
// TP84 audio output stage: 48 kHz decimation, dial gain and optional amplifier low-pass
// on one shared multiplier. TP84_VOLUME_LPF_EN enables the DIFF/MAC low-pass path.
module tp84_volume_stage
  import tp84_snd_pkg::*;
#(
  parameter int DIV = 1024
) (
  input  logic                       clk_49m,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] in,
  input  logic [2:0]                 vol,
  output logic signed [SAMPLE_W-1:0] out,
  output logic                       sample_valid,
  output logic                       busy
);

  localparam int CNT_W = 10;

  logic [CNT_W-1:0] cnt;
  logic             strobe;
  state_t           state, state_n;

  // op_a holds the captured sample x during GAIN and the difference d during MAC
  logic signed [16:0] op_a, op_b;
  logic signed [33:0] prod, prod_g;
  logic signed [SAMPLE_W-1:0] g, g_sat;

  assign strobe = (cnt == CNT_W'(DIV - 1));
  assign busy   = (state != ST_IDLE);
  assign prod   = op_a * op_b;
  assign prod_g = prod >>> 8;

  tp84_sat16 #(.IN_W(34)) u_sat_gain (
    .din  (prod_g),
    .dout (g_sat)
  );

`ifdef TP84_VOLUME_LPF_EN
  logic [2:0]                 v;
  logic signed [SAMPLE_W-1:0] y, y_sat;
  logic signed [16:0]         diff;
  logic signed [33:0]         prod_a, mac_sum;

  assign diff    = {g[15], g} - {y[15], y};
  assign prod_a  = prod >>> 15;
  assign mac_sum = {{18{y[15]}}, y} + prod_a;

  tp84_sat16 #(.IN_W(34)) u_sat_mac (
    .din  (mac_sum),
    .dout (y_sat)
  );
`endif

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (strobe)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (strobe) state_n = ST_GAIN;
`ifdef TP84_VOLUME_LPF_EN
      ST_GAIN: state_n = ST_DIFF;
      ST_DIFF: state_n = ST_MAC;
      ST_MAC:  state_n = ST_OUT;
`else
      ST_GAIN: state_n = ST_OUT;
`endif
      ST_OUT:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      op_a         <= '0;
      op_b         <= '0;
      g            <= '0;
      out          <= '0;
      sample_valid <= 1'b0;
`ifdef TP84_VOLUME_LPF_EN
      v            <= '0;
      y            <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            op_a <= {in[15], in};
            op_b <= {8'd0, GAIN_TAB[vol]};
`ifdef TP84_VOLUME_LPF_EN
            v    <= vol;
`endif
          end
        end
        ST_GAIN: g <= g_sat;
`ifdef TP84_VOLUME_LPF_EN
        ST_DIFF: begin
          op_a <= diff;
          op_b <= {1'b0, ALPHA_TAB[v]};
        end
        ST_MAC: y <= y_sat;
        ST_OUT: begin
          out          <= y;
          sample_valid <= 1'b1;
        end
`else
        ST_OUT: begin
          out          <= g;
          sample_valid <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
